pkmc_sdram_wbif: RTL
====================

// Module: pkmc_sdram_wbif
// PURPOSE
//  Wishbone classic slave front-end for the PKMC SDRAM path; sits directly upstream of
//  pkmc_sdramctrl_top. Latches one Wishbone access, holds a stable request (addr/data/sel/we/
//  active) to the SDRAM controller until it acks, returns read data and wb_ack, answers the
//  controller's refresh interrupt (sdramIRQ/sdramIRQack) between accesses, and flags hung
//  accesses with wb_err via a timeout counter.
// PARAMETERS
//  ADDR_W   26   address bits forwarded (= `ADDR_I_WIDTH); bits [25:24] select bank
//  DAT_W    32   data width (= `DAT_I_WIDTH)
//  SEL_W    4    byte-select width (= `SEL_I_WIDTH)
//  TIMEOUT  255  cycles in REQ without ack_i before wb_err; 1..2**CNT_W-1
//  CNT_W    8    timeout counter width
// PORTS
//  clk          in   1       system clock, all logic rising-edge
//  rst          in   1       asynchronous, active-low reset
//  wb_adr_i     in   32      Wishbone address
//  wb_dat_i     in   DAT_W   Wishbone write data
//  wb_sel_i     in   SEL_W   Wishbone byte selects (active high)
//  wb_we_i      in   1       Wishbone write enable
//  wb_cyc_i     in   1       Wishbone cycle
//  wb_stb_i     in   1       Wishbone strobe (already address-decoded for SDRAM)
//  wb_dat_o     out  DAT_W   registered read data
//  wb_ack_o     out  1       one-cycle access acknowledge
//  wb_err_o     out  1       one-cycle timeout error
//  addr_o       out  ADDR_W  to controller addr_i
//  dat_o        out  DAT_W   to controller dat_i
//  byte_sel_o   out  SEL_W   to controller byte_sel (active high; controller inverts)
//  we_o         out  1       to controller we_i
//  active_o     out  1       to controller active_i
//  ctrl_dat_i   in   DAT_W   from controller dat_o
//  ctrl_ack_i   in   1       from controller ack_o
//  sdramIRQ_i   in   1       refresh request from controller
//  sdramIRQack_o out 1       refresh grant to controller
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; every output 0; counter 0. Reset mid-access drops
//   active_o immediately; no ack/err is issued for the aborted access.
//  States IDLE, REQ, ACK, ERR, REFRESH (registered; outputs registered, no comb in->out paths).
//  IDLE: sdramIRQ_i=1 -> REFRESH (refresh wins over a simultaneous wb request).
//   else wb_cyc_i&wb_stb_i -> latch addr_o=wb_adr_i[ADDR_W-1:0], dat_o, byte_sel_o, we_o;
//   active_o=1 next cycle; counter=0; -> REQ.
//  REQ: request outputs held constant. ctrl_ack_i=1 -> active_o=0; if !we_o capture
//   wb_dat_o<=ctrl_dat_i; -> ACK. Else counter+1; counter==TIMEOUT-1 -> active_o=0, -> ERR.
//   wb_cyc_i dropping in REQ does not abort (controller command in flight): access completes,
//   ACK is skipped (go straight to IDLE), wb_dat_o still updated on reads.
//  ACK: wb_ack_o=1 for exactly this cycle -> IDLE. Earliest next latch is cycle after ACK,
//   so a master holding stb after ack starts a new access (back-to-back, 1 idle cycle min).
//  ERR: wb_err_o=1 for one cycle -> IDLE; wb_dat_o unchanged.
//  REFRESH: sdramIRQack_o=1 for the first cycle only; wait (active_o=0) until sdramIRQ_i=0,
//   then -> IDLE. Pending wb request stays stalled (no ack) and is served afterwards.
//  wb_ack_o and wb_err_o never both 1; active_o never 1 outside REQ; sdramIRQack_o never
//   coincides with active_o. ctrl_ack_i outside REQ is ignored.
//  Latency (ack_i in controller cycle N): wb_ack_o in N+1; wb_dat_o valid same cycle.
// TESTING
//  Read: stb adr=0x0100_0040, ctrl_ack 3 cycles after active, ctrl_dat=0xDEADBEEF ->
//   addr_o=0x100_0040, bank=01, wb_ack 1 cycle with wb_dat_o=0xDEADBEEF, active_o 3 cycles.
//  Write: we=1 dat=0x12345678 sel=4'b0011 -> dat_o/byte_sel_o/we_o stable entire REQ;
//   one wb_ack; wb_dat_o unchanged.
//  Refresh vs request same cycle: sdramIRQ_i=1 and stb=1 in IDLE -> sdramIRQack_o pulse,
//   active_o stays 0 until IRQ drops, then access runs and acks.
//  Timeout: TIMEOUT=16, ctrl_ack never -> active_o 16 cycles, then wb_err 1 cycle, no ack.
//  cyc drop in REQ: deassert cyc after 1 cycle, ack_i later -> no wb_ack, back to IDLE.
//  Reset mid-REQ: rst=0 async -> active_o=0 within same cycle; after release IDLE, outputs 0.

Source files
------------

// File: rtl/pkmc_sdram_wbif.sv
// Wishbone classic slave front-end for the PKMC SDRAM controller: latches one access,
// holds a stable request until the controller acks, and arbitrates refresh between accesses.
module pkmc_sdram_wbif #(
  parameter int ADDR_W  = 26,
  parameter int DAT_W   = 32,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       wb_adr_i,
  input  logic [DAT_W-1:0]  wb_dat_i,
  input  logic [SEL_W-1:0]  wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic [DAT_W-1:0]  wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DAT_W-1:0]  dat_o,
  output logic [SEL_W-1:0]  byte_sel_o,
  output logic              we_o,
  output logic              active_o,
  input  logic [DAT_W-1:0]  ctrl_dat_i,
  input  logic              ctrl_ack_i,
  input  logic              sdramIRQ_i,
  output logic              sdramIRQack_o,
  output logic [2:0]        state_o
);

  // Handshake: a Wishbone access is accepted in IDLE when cyc&stb are high and no refresh
  // is pending; it is finished by exactly one of wb_ack_o or wb_err_o (or silently when the
  // master dropped cyc mid-access). The controller sees active_o high for the whole REQ
  // phase with addr/dat/sel/we frozen, and completes it with a one-cycle ctrl_ack_i.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_ACK     = 3'd2,
    S_ERR     = 3'd3,
    S_REFRESH = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               drop_q, drop_d;
  logic               irqack_q, irqack_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [DAT_W-1:0]   dat_q;
  logic [SEL_W-1:0]   sel_q;
  logic               we_q;
  logic [DAT_W-1:0]   rdat_q;
  logic               latch;
  logic               capture;
  logic               unused_adr;

  assign unused_adr = ^wb_adr_i[31:ADDR_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    irqack_d = 1'b0;
    latch    = 1'b0;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sdramIRQ_i) begin
          state_d  = S_REFRESH;
          irqack_d = 1'b1;
        end else if (wb_cyc_i && wb_stb_i) begin
          latch   = 1'b1;
          cnt_d   = '0;
          drop_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!wb_cyc_i) drop_d = 1'b1;
        if (ctrl_ack_i) begin
          capture = !we_q;
          // An abandoned cycle still completes at the controller but is never acked.
          state_d = (drop_q || !wb_cyc_i) ? S_IDLE : S_ACK;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK:     state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      S_REFRESH: if (!sdramIRQ_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      irqack_q <= 1'b0;
      addr_q   <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      rdat_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      irqack_q <= irqack_d;
      if (latch) begin
        addr_q <= wb_adr_i[ADDR_W-1:0];
        dat_q  <= wb_dat_i;
        sel_q  <= wb_sel_i;
        we_q   <= wb_we_i;
      end
      if (capture) rdat_q <= ctrl_dat_i;
    end
  end

  // All outputs are decodes of registered state, so no input reaches an output combinationally.
  assign active_o      = (state_q == S_REQ);
  assign wb_ack_o      = (state_q == S_ACK);
  assign wb_err_o      = (state_q == S_ERR);
  assign sdramIRQack_o = irqack_q;
  assign wb_dat_o      = rdat_q;
  assign addr_o        = addr_q;
  assign dat_o         = dat_q;
  assign byte_sel_o    = sel_q;
  assign we_o          = we_q;
  assign state_o       = state_q;

endmodule
